// File: rtl/ram_fifo_ctrl_if.sv
// Handshake and RAM-port bundle for ram_fifo_ctrl.
// slave = controller side, master = producer/consumer/RAM environment side.
interface ram_fifo_ctrl_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 2
);
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_ready;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              ram_en;
  logic              ram_rw;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data_in;
  logic [DATA_W-1:0] ram_data_out;
  logic              err;

  modport master (
    output wr_valid, wr_data, rd_ready, ram_data_out,
    input  wr_ready, rd_valid, rd_data, full, empty, count,
           ram_en, ram_rw, ram_addr, ram_data_in, err
  );

  modport slave (
    input  wr_valid, wr_data, rd_ready, ram_data_out,
    output wr_ready, rd_valid, rd_data, full, empty, count,
           ram_en, ram_rw, ram_addr, ram_data_in, err
  );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller around a single-port synchronous RAM with a registered head word.
// Optional sticky overflow/underflow flag: define RAM_FIFO_ERR_EN.
module ram_fifo_ctrl #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 2
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  ram_fifo_ctrl_if.slave s_bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]   C_CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   C_CNT_ZERO = (ADDR_W+1)'(0);
  localparam logic [ADDR_W:0]   C_CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] C_PTR_ONE  = ADDR_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_RD_WAIT = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_rd_data;

  logic              w_pop;
  logic              w_rd_go;
  logic              w_wr_go;
  logic              w_capture;
  logic              w_ram_en;
  logic              w_ram_rw;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [DATA_W-1:0] w_ram_data_in;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: a read issue always costs exactly one wait cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_rd_go) begin
          w_state_nxt = ST_RD_WAIT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RD_WAIT: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Output logic: read issue beats write on the shared RAM port
  always_comb begin
    w_pop         = r_rd_valid && s_bus.rd_ready;
    w_rd_go       = 1'b0;
    w_wr_go       = 1'b0;
    w_capture     = 1'b0;
    w_ram_en      = 1'b0;
    w_ram_rw      = 1'b0;
    w_ram_addr    = '0;
    w_ram_data_in = '0;

    case (r_state)
      ST_IDLE: begin
        w_capture = 1'b0;
        if ((r_count != C_CNT_ZERO) && (!r_rd_valid || w_pop)) begin
          w_rd_go = 1'b1;
        end else begin
          w_rd_go = 1'b0;
        end
      end
      ST_RD_WAIT: begin
        w_capture = 1'b1;
        w_rd_go   = 1'b0;
      end
      default: begin
        w_capture = 1'b0;
        w_rd_go   = 1'b0;
      end
    endcase

    // The write gate also looks at reset so no RAM write can leak out while held in reset
    if (i_rst_n && s_bus.wr_valid && (r_count != C_CNT_FULL) && !w_rd_go) begin
      w_wr_go = 1'b1;
    end else begin
      w_wr_go = 1'b0;
    end

    if (w_rd_go) begin
      w_ram_en   = 1'b1;
      w_ram_rw   = 1'b0;
      w_ram_addr = r_rd_ptr;
    end else if (w_wr_go) begin
      w_ram_en      = 1'b1;
      w_ram_rw      = 1'b1;
      w_ram_addr    = r_wr_ptr;
      w_ram_data_in = s_bus.wr_data;
    end else begin
      w_ram_en = 1'b0;
    end
  end

  // Pointers and RAM occupancy; rd_go and wr_go are mutually exclusive
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_rd_go) begin
      r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      r_count  <= r_count - C_CNT_ONE;
    end else if (w_wr_go) begin
      r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      r_count  <= r_count + C_CNT_ONE;
    end
  end

  // Head-word register: capture wins over pop so rd_valid stays up on back-to-back
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else if (w_capture) begin
      r_rd_valid <= 1'b1;
      r_rd_data  <= s_bus.ram_data_out;
    end else if (w_pop) begin
      r_rd_valid <= 1'b0;
    end
  end

`ifdef RAM_FIFO_ERR_EN
  logic r_err;

  // Sticky protocol-violation flag
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err <= 1'b0;
    end else if ((s_bus.wr_valid && (r_count == C_CNT_FULL)) ||
                 (s_bus.rd_ready && !r_rd_valid)) begin
      r_err <= 1'b1;
    end
  end

  assign s_bus.err = r_err;
`else
  assign s_bus.err = 1'b0;
`endif

  assign s_bus.wr_ready    = w_wr_go;
  assign s_bus.rd_valid    = r_rd_valid;
  assign s_bus.rd_data     = r_rd_data;
  assign s_bus.full        = (r_count == C_CNT_FULL);
  assign s_bus.empty       = (r_count == C_CNT_ZERO) && !r_rd_valid;
  assign s_bus.count       = r_count;
  assign s_bus.ram_en      = w_ram_en;
  assign s_bus.ram_rw      = w_ram_rw;
  assign s_bus.ram_addr    = w_ram_addr;
  assign s_bus.ram_data_in = w_ram_data_in;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: directed scenarios plus random traffic against a queue model.
module tb_ram_fifo_ctrl;

  localparam int DATA_W = 4;
  localparam int ADDR_W = 2;
  localparam int DEPTH  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  ram_fifo_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  ram_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .s_bus   (bus)
  );

  // Behavioural single-port RAM: write-through-clock, read data one cycle later
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ram_q = '0;
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_rw) mem[bus.ram_addr] <= bus.ram_data_in;
      else            ram_q <= mem[bus.ram_addr];
    end
  end
  assign bus.ram_data_out = ram_q;

  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] popped[$];
  int  wr_total, rd_issue;
  bit  in_wait, err_exp, last_acc;
  int  n_chk  = 0;
  int  n_pass = 0;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // Per-cycle check of every output against the queue model, then model update
  task automatic monitor();
    bit issue, wr_acc, pop, exp_issue, exp_wr_ready;
    issue  = bus.ram_en && !bus.ram_rw;
    wr_acc = bus.wr_valid && bus.wr_ready;
    pop    = bus.rd_valid && bus.rd_ready;
    chk_val("occupancy", 32'(bus.count) + 32'(bus.rd_valid) + 32'(in_wait), 32'(q.size()));
    chk_val("full", 32'(bus.full), 32'(bus.count == 3'd4));
    chk_val("empty", 32'(bus.empty), 32'((bus.count == 3'd0) && !bus.rd_valid));
    exp_issue = !in_wait && (bus.count != 3'd0) && (!bus.rd_valid || bus.rd_ready);
    chk_val("rd_issue", 32'(issue), 32'(exp_issue));
    if (issue) begin
      chk_val("rd_addr", 32'(bus.ram_addr), 32'(rd_issue % DEPTH));
      chk_val("wr_ready_on_issue", 32'(bus.wr_ready), 32'd0);
    end else begin
      exp_wr_ready = bus.wr_valid && (bus.count < 3'd4);
      chk_val("wr_ready", 32'(bus.wr_ready), 32'(exp_wr_ready));
    end
    if (wr_acc) begin
      chk_val("wr_rw", 32'(bus.ram_rw), 32'd1);
      chk_val("wr_addr", 32'(bus.ram_addr), 32'(wr_total % DEPTH));
      chk_val("wr_din", 32'(bus.ram_data_in), 32'(bus.wr_data));
    end
    if (!issue && !wr_acc) chk_val("ram_en_idle", 32'(bus.ram_en), 32'd0);
    if (bus.rd_valid && q.size() > 0) chk_val("rd_data", 32'(bus.rd_data), 32'(q[0]));
    chk_val("err", 32'(bus.err), 32'(err_exp));
`ifdef RAM_FIFO_ERR_EN
    if ((bus.wr_valid && bus.full) || (bus.rd_ready && !bus.rd_valid)) err_exp = 1'b1;
`endif
    if (pop && q.size() > 0) popped.push_back(q.pop_front());
    if (wr_acc) begin
      q.push_back(bus.wr_data);
      wr_total++;
    end
    if (issue) rd_issue++;
    in_wait = issue;
  endtask

  task automatic cyc();
    @(negedge clk);
    last_acc = bus.wr_valid && bus.wr_ready;
    monitor();
    @(posedge clk);
    #1;
  endtask

  // Asserted one step after a rising edge; outputs must react without a clock
  task automatic apply_reset(input string tag);
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;
    rst_n = 1'b0;
    q.delete();
    wr_total = 0; rd_issue = 0; in_wait = 1'b0; err_exp = 1'b0;
    #1;
    chk_val({tag, "_rd_valid"}, 32'(bus.rd_valid), 32'd0);
    chk_val({tag, "_count"},    32'(bus.count),    32'd0);
    chk_val({tag, "_ram_en"},   32'(bus.ram_en),   32'd0);
    chk_val({tag, "_wr_ready"}, 32'(bus.wr_ready), 32'd0);
    chk_val({tag, "_empty"},    32'(bus.empty),    32'd1);
    chk_val({tag, "_full"},     32'(bus.full),     32'd0);
    chk_val({tag, "_rd_data"},  32'(bus.rd_data),  32'd0);
    chk_val({tag, "_err"},      32'(bus.err),      32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic push_word(input logic [DATA_W-1:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    last_acc = 1'b0;
    for (int k = 0; k < 8 && !last_acc; k++) cyc();
    if (!last_acc) chk_val("push_timeout", 32'd0, 32'd1);
    bus.wr_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b1;
    for (int k = 0; k < 40 && q.size() > 0; k++) cyc();
    chk_val({tag, "_drained"}, 32'(q.size()), 32'd0);
    bus.rd_ready = 1'b0;
    cyc();
  endtask

  logic [DATA_W-1:0] seq[5];

  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.rd_ready = 1'b0;
    @(posedge clk);
    #1;
    apply_reset("rst");

    // Single word: write accepted on first edge after release, visible three cycles later
    bus.wr_valid = 1'b1;
    bus.wr_data  = 4'd15;
    #1;
    chk_val("p32_wr_ready", 32'(bus.wr_ready), 32'd1);
    chk_val("p32_ram_rw",   32'(bus.ram_rw),   32'd1);
    chk_val("p32_addr",     32'(bus.ram_addr), 32'd0);
    cyc();
    bus.wr_valid = 1'b0;
    cyc();
    #1;
    chk_val("p32_not_yet", 32'(bus.rd_valid), 32'd0);
    cyc();
    #1;
    chk_val("p32_rd_valid", 32'(bus.rd_valid), 32'd1);
    chk_val("p32_rd_data",  32'(bus.rd_data),  32'd15);
    chk_val("p32_empty",    32'(bus.empty),    32'd0);
    bus.rd_ready = 1'b1;
    cyc();
    bus.rd_ready = 1'b0;
    cyc();

    // Fill with the consumer stalled
    seq[0] = 4'd15; seq[1] = 4'd12; seq[2] = 4'd10; seq[3] = 4'd9; seq[4] = 4'd7;
    for (int i = 0; i < 5; i++) begin
      push_word(seq[i]);
      if (i == 3) chk_val("p33_count3", 32'(bus.count), 32'd3);
    end
    chk_val("p33_count4", 32'(bus.count), 32'd4);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 4'd5;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk_val("p33_held_off", 32'(bus.wr_ready), 32'd0);
      chk_val("p33_full",     32'(bus.full),     32'd1);
      chk_val("p33_head",     32'(bus.rd_data),  32'd15);
      cyc();
    end
    bus.wr_valid = 1'b0;
    #1;
`ifdef RAM_FIFO_ERR_EN
    chk_val("p37_err", 32'(bus.err), 32'd1);
`else
    chk_val("p37_err", 32'(bus.err), 32'd0);
`endif

    // Drain in order; read addresses wrap through the monitor's rd_addr check
    popped.delete();
    bus.rd_ready = 1'b1;
    for (int k = 0; k < 40 && popped.size() < 5; k++) cyc();
    bus.rd_ready = 1'b0;
    cyc();
    chk_val("p34_pop_count", 32'(popped.size()), 32'd5);
    for (int i = 0; i < 5 && i < popped.size(); i++) chk_val("p34_order", 32'(popped[i]), 32'(seq[i]));
    #1;
    chk_val("p34_empty", 32'(bus.empty), 32'd1);

    // Read issue blocks a continuously offered write for exactly one cycle
    bus.wr_valid = 1'b1;
    bus.wr_data  = 4'd3;
    cyc();
    bus.wr_data  = 4'd6;
    #1;
    chk_val("p35_issue_en", 32'(bus.ram_en),   32'd1);
    chk_val("p35_issue_rw", 32'(bus.ram_rw),   32'd0);
    chk_val("p35_blocked",  32'(bus.wr_ready), 32'd0);
    cyc();
    #1;
    chk_val("p35_taken", 32'(bus.wr_ready), 32'd1);
    cyc();
    drain("p35");

    // Reset while a read is in flight
    bus.wr_valid = 1'b1;
    bus.wr_data  = 4'd11;
    cyc();
    bus.wr_valid = 1'b0;
    cyc();
    apply_reset("p36");
    for (int k = 0; k < 4; k++) begin
      #1;
      chk_val("p36_no_stale", 32'(bus.rd_valid), 32'd0);
      cyc();
    end

    // Random traffic, first consumer-starved then consumer-eager
    for (int k = 0; k < 400; k++) begin
      bus.wr_valid = ($urandom_range(0, 99) < 60);
      bus.wr_data  = 4'($urandom);
      bus.rd_ready = ($urandom_range(0, 99) < ((k < 200) ? 30 : 80));
      cyc();
    end
    drain("rand");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ram_fifo_ctrl.md
RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 4, word width (matches RAM_4x4 data width).
REQ-002 SHALL have parameter ADDR_W, default 2, RAM address width; depth = 2**ADDR_W = 4.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 wr_valid  input  1  producer offers wr_data.
REQ-006 wr_data  input  DATA_W  word to enqueue.
REQ-007 wr_ready  output  1  write accepted this cycle when wr_valid && wr_ready.
REQ-008 rd_valid  output  1  rd_data holds the oldest word.
REQ-009 rd_data  output  DATA_W  head word, registered.
REQ-010 rd_ready  input  1  consumer takes rd_data when rd_valid && rd_ready.
REQ-011 full / empty  output  1 each  count==4 / count==0 && !rd_valid.
REQ-012 count  output  ADDR_W+1  words held in RAM, excluding rd_data register (0..4).
REQ-013 ram_en, ram_rw, ram_addr, ram_data_in  output  1,1,ADDR_W,DATA_W  RAM port drive; ram_rw=1 write, 0 read.
REQ-014 ram_data_out  input  DATA_W  RAM read data, valid the cycle after a read is issued.
REQ-015 err  output  1  sticky overflow/underflow flag (see Configuration).

Function
REQ-016 SHALL keep wr_ptr, rd_ptr (ADDR_W bits, wrap 3->0), count, a 1-word output register and state {IDLE, RD_WAIT}.
REQ-017 Read issue (rd_go) SHALL occur in IDLE when count>0 and output register is empty or being popped this cycle: ram_en=1, ram_rw=0, ram_addr=rd_ptr; rd_ptr+1, count-1, state->RD_WAIT.
REQ-018 Write (wr_go) SHALL occur when wr_valid && count<4 && !rd_go: wr_ready=1, ram_en=1, ram_rw=1, ram_addr=wr_ptr, ram_data_in=wr_data; wr_ptr+1, count+1.
REQ-019 Read issue SHALL have priority over write; wr_ready SHALL be 0 in any cycle with rd_go.
REQ-020 In RD_WAIT SHALL capture ram_data_out into rd_data at the clock edge, set rd_valid, return to IDLE; writes allowed during RD_WAIT.
REQ-021 ram_* outputs SHALL be combinational from registered state and inputs; ram_en=0 when neither rd_go nor wr_go.
REQ-022 Pop (rd_valid && rd_ready) without simultaneous capture SHALL clear rd_valid next cycle; with capture, rd_valid stays 1 and rd_data updates.
REQ-023 Latency: write accepted into empty block at cycle N -> rd_valid=1 at N+3; steady pop throughput SHALL be 1 word per 2 cycles.
REQ-024 count==4: wr_ready=0, no RAM write, contents unchanged.
REQ-025 count+1 and count-1 SHALL never occur in the same cycle (single RAM port).
REQ-026 Data SHALL be delivered in strict write order across pointer wrap.

Reset
REQ-027 rst_n low SHALL immediately force wr_ptr=0, rd_ptr=0, count=0, state=IDLE, rd_valid=0, rd_data=0, err=0; hence ram_en=0, wr_ready=0, empty=1, full=0.
REQ-028 Reset mid-read (RD_WAIT) SHALL discard the in-flight word; no capture after release.
REQ-029 First accepted write SHALL be possible in the first clock edge after rst_n deasserts.

Configuration
REQ-030 Macro RAM_FIFO_ERR_EN defined: err SHALL set on wr_valid while full, or rd_ready while !rd_valid, and hold until reset.
REQ-031 Macro undefined: err SHALL be constant 0 and no error logic SHALL be synthesized.

Verification
REQ-032 Reset, push 4'd15 once -> wr_ready=1, ram_rw=1 addr 0, rd_valid=1 with rd_data=15 three cycles later, empty=0.
REQ-033 rd_ready=0, push 15,12,10,9,7 -> rd_data=15, count reaches 3 then 4 (7 accepted), sixth push held off, full=1, wr_ready=0.
REQ-034 Continue with rd_ready=1 -> pops 15,12,10,9,7 in order, addresses wrap 3->0, empty=1 at end.
REQ-035 wr_valid=1 constantly with output register empty and count>0 -> wr_ready=0 in read-issue cycle, write taken next cycle.
REQ-036 rst_n low while state=RD_WAIT -> rd_valid=0, count=0, ram_en=0 immediately, no stale capture after release.
REQ-037 RAM_FIFO_ERR_EN set: push while full -> err=1 sticky; without macro same stimulus -> err=0.
